estagio_busca: RTL and testbench



---
 rtl/mips_pkg.sv | 24 ++
 rtl/contador_sat.sv | 25 ++
 rtl/estagio_busca.sv | 116 +++++++++++
 tb/tb_estagio_busca.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline.
//
// Fetch, execute and the hazard unit all import these so that datapath
// widths, the bubble word and the opcode encodings stay consistent.
//
// Contents:
//   PC_W, INSTR_W   word-addressed PC width and instruction width
//   NOP_WORD        word placed in IF/ID on a squash or bubble
//   OP_*            primary opcode field values (instr[31:26])
package mips_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

// File: rtl/contador_sat.sv
// Saturating up-counter.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset, clears the count
//   en     count one step on this edge
//   count  current value; sticks at all-ones instead of wrapping
module contador_sat #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/estagio_busca.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Owns the PC, drives the synchronous instruction memory (one cycle read
// latency) and registers the returned word into the IF/ID register along
// with its address and a valid flag. Stall holds everything; redirect
// restarts fetch at a new target and squashes the wrong-path word.
//
// Ports:
//   fe_in_clk          pipeline clock
//   fe_in_rst          asynchronous active-low reset
//   fe_in_stall        hold IF and IF/ID this cycle
//   fe_in_redirect     taken branch / jump from execute (beats stall)
//   fe_in_target       redirect target address
//   fe_in_mem_q        instruction memory read data
//   fe_out_mem_addr    instruction memory address (combinational)
//   fe_out_ir          IF/ID instruction register
//   fe_out_ir_pc       address of fe_out_ir
//   fe_out_ir_valid    fe_out_ir holds a real instruction
//   fe_out_fetch_cnt   valid words delivered to decode (saturating)
//   fe_out_bubble_cnt  bubbles loaded into IF/ID after startup (saturating)
module estagio_busca #(
    parameter int                   PC_W     = mips_pkg::PC_W,
    parameter int                   INSTR_W  = mips_pkg::INSTR_W,
    parameter logic [INSTR_W-1:0]   NOP_WORD = mips_pkg::NOP_WORD
) (
    input  logic               fe_in_clk,
    input  logic               fe_in_rst,
    input  logic               fe_in_stall,
    input  logic               fe_in_redirect,
    input  logic [PC_W-1:0]    fe_in_target,
    input  logic [INSTR_W-1:0] fe_in_mem_q,
    output logic [PC_W-1:0]    fe_out_mem_addr,
    output logic [INSTR_W-1:0] fe_out_ir,
    output logic [PC_W-1:0]    fe_out_ir_pc,
    output logic               fe_out_ir_valid,
    output logic [15:0]        fe_out_fetch_cnt,
    output logic [15:0]        fe_out_bubble_cnt
);

    // pc_q  : next address to request from memory
    // pc_d1 : address whose data is currently on fe_in_mem_q
    // v_d1  : that data is a real instruction
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d1;
    logic            v_d1;

    // Set by reset, cleared by the first edge afterwards. The first edge
    // always loads an empty IF/ID (nothing has been read yet) and that
    // startup slot is not counted as a bubble.
    logic            first_q;

    logic            fetch_en;
    logic            bubble_en;

    // While stalled the memory re-reads the in-flight address so that
    // fe_in_mem_q still belongs to pc_d1 when the stall drops.
    always_comb begin
        fe_out_mem_addr = pc_q;
        if (fe_in_redirect) begin
            fe_out_mem_addr = fe_in_target;
        end else if (fe_in_stall) begin
            fe_out_mem_addr = pc_d1;
        end
    end

    always_ff @(posedge fe_in_clk or negedge fe_in_rst) begin
        if (!fe_in_rst) begin
            pc_q            <= '0;
            pc_d1           <= '0;
            v_d1            <= 1'b0;
            fe_out_ir       <= NOP_WORD;
            fe_out_ir_pc    <= '0;
            fe_out_ir_valid <= 1'b0;
            first_q         <= 1'b1;
        end else begin
            first_q <= 1'b0;
            if (fe_in_redirect) begin
                // The word on fe_in_mem_q is wrong-path: replace with a bubble.
                // The target is being read this edge, so it lands in pc_d1.
                pc_q            <= fe_in_target + 1'b1;
                pc_d1           <= fe_in_target;
                v_d1            <= 1'b1;
                fe_out_ir       <= NOP_WORD;
                fe_out_ir_valid <= 1'b0;
            end else if (!fe_in_stall) begin
                pc_q            <= pc_q + 1'b1;
                pc_d1           <= pc_q;
                v_d1            <= 1'b1;
                fe_out_ir       <= fe_in_mem_q;
                fe_out_ir_pc    <= pc_d1;
                fe_out_ir_valid <= v_d1;
            end
        end
    end

    // Counter enables follow what IF/ID loads on this edge. A redirect
    // edge always loads a bubble, even with stall asserted.
    assign fetch_en  = !fe_in_redirect && !fe_in_stall && v_d1;
    assign bubble_en = !first_q &&
                       (fe_in_redirect || (!fe_in_stall && !v_d1));

    contador_sat #(.W(16)) u_fetch_cnt (
        .clk   (fe_in_clk),
        .rst_n (fe_in_rst),
        .en    (fetch_en),
        .count (fe_out_fetch_cnt)
    );

    contador_sat #(.W(16)) u_bubble_cnt (
        .clk   (fe_in_clk),
        .rst_n (fe_in_rst),
        .en    (bubble_en),
        .count (fe_out_bubble_cnt)
    );

endmodule

// File: tb/tb_estagio_busca.sv
// Directed testbench for estagio_busca with a synchronous instruction
// memory model. Inputs change 1 time unit after the rising edge and
// outputs are checked at that point as well.
module tb_estagio_busca;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               stall;
    logic               redirect;
    logic [PC_W-1:0]    target;
    logic [INSTR_W-1:0] mem_q;
    logic [PC_W-1:0]    mem_addr;
    logic [INSTR_W-1:0] ir;
    logic [PC_W-1:0]    ir_pc;
    logic               ir_valid;
    logic [15:0]        fetch_cnt;
    logic [15:0]        bubble_cnt;

    int vectors     = 0;
    int miscompares = 0;

    logic [INSTR_W-1:0] exp_q[$];

    estagio_busca dut (
        .fe_in_clk         (clk),
        .fe_in_rst         (rst),
        .fe_in_stall       (stall),
        .fe_in_redirect    (redirect),
        .fe_in_target      (target),
        .fe_in_mem_q       (mem_q),
        .fe_out_mem_addr   (mem_addr),
        .fe_out_ir         (ir),
        .fe_out_ir_pc      (ir_pc),
        .fe_out_ir_valid   (ir_valid),
        .fe_out_fetch_cnt  (fetch_cnt),
        .fe_out_bubble_cnt (bubble_cnt)
    );

    // ---------------- instruction memory model ----------------
    logic [INSTR_W-1:0] mem [0:1023];
    always @(posedge clk) mem_q <= mem[mem_addr];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // ---------------- tests ----------------
    // Reset values, then the first three edges: startup slot, pc0, pc1.
    task automatic test_reset();
        stall = 1'b0; redirect = 1'b0; target = '0;
        rst = 1'b0;
        tick(); tick();
        vectors++; if (ir !== 32'h0) begin miscompares++; $display("FAIL reset_ir got %h exp %h", ir, 32'h0); end
        vectors++; if (ir_pc !== 10'd0) begin miscompares++; $display("FAIL reset_pc got %0d exp 0", ir_pc); end
        vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", ir_valid); end
        vectors++; if (fetch_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_fetch got %0d exp 0", fetch_cnt); end
        vectors++; if (bubble_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_bubble got %0d exp 0", bubble_cnt); end
        vectors++; if (mem_addr !== 10'd0) begin miscompares++; $display("FAIL reset_addr got %0d exp 0", mem_addr); end
        rst = 1'b1;
        tick();
        vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL first_edge_valid got %b exp 0", ir_valid); end
        vectors++; if (bubble_cnt !== 16'd0) begin miscompares++; $display("FAIL first_edge_bubble got %0d exp 0", bubble_cnt); end
        exp_q.push_back(32'h2001_0005);
        exp_q.push_back(32'h2002_0003);
        for (int i = 0; i < 2; i++) begin
            logic [INSTR_W-1:0] e;
            tick();
            e = exp_q.pop_front();
            vectors++; if (ir !== e) begin miscompares++; $display("FAIL start_ir%0d got %h exp %h", i, ir, e); end
            vectors++; if (ir_pc !== 10'(i)) begin miscompares++; $display("FAIL start_pc%0d got %0d exp %0d", i, ir_pc, i); end
            vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("FAIL start_valid%0d got %b exp 1", i, ir_valid); end
        end
        vectors++; if (fetch_cnt !== 16'd2) begin miscompares++; $display("FAIL start_fetch got %0d exp 2", fetch_cnt); end
    endtask

    // IR holds pc1; stall two cycles, then pc2, pc3, pc4 with no skip/dup.
    task automatic test_stall();
        stall = 1'b1;
        #1;
        vectors++; if (mem_addr !== 10'd2) begin miscompares++; $display("FAIL stall_addr got %0d exp 2", mem_addr); end
        tick(); tick();
        vectors++; if (ir !== 32'h2002_0003) begin miscompares++; $display("FAIL stall_ir got %h exp 20020003", ir); end
        vectors++; if (ir_pc !== 10'd1) begin miscompares++; $display("FAIL stall_pc got %0d exp 1", ir_pc); end
        vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid got %b exp 1", ir_valid); end
        vectors++; if (fetch_cnt !== 16'd2) begin miscompares++; $display("FAIL stall_fetch got %0d exp 2", fetch_cnt); end
        vectors++; if (mem_addr !== 10'd2) begin miscompares++; $display("FAIL stall_addr2 got %0d exp 2", mem_addr); end
        stall = 1'b0;
        #1;
        vectors++; if (mem_addr !== 10'd3) begin miscompares++; $display("FAIL unstall_addr got %0d exp 3", mem_addr); end
        exp_q.push_back(32'h0022_1820);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'hC000_0004);
        for (int i = 2; i < 5; i++) begin
            logic [INSTR_W-1:0] e;
            tick();
            e = exp_q.pop_front();
            vectors++; if (ir !== e) begin miscompares++; $display("FAIL post_stall_ir%0d got %h exp %h", i, ir, e); end
            vectors++; if (ir_pc !== 10'(i)) begin miscompares++; $display("FAIL post_stall_pc%0d got %0d exp %0d", i, ir_pc, i); end
        end
        vectors++; if (fetch_cnt !== 16'd5) begin miscompares++; $display("FAIL post_stall_fetch got %0d exp 5", fetch_cnt); end
        vectors++; if (bubble_cnt !== 16'd0) begin miscompares++; $display("FAIL post_stall_bubble got %0d exp 0", bubble_cnt); end
    endtask

    // IR holds pc4; redirect to 8 -> bubble, mem[8]@8, mem[9]@9.
    task automatic test_redirect();
        redirect = 1'b1; target = 10'd8;
        #1;
        vectors++; if (mem_addr !== 10'd8) begin miscompares++; $display("FAIL redir_addr got %0d exp 8", mem_addr); end
        tick();
        redirect = 1'b0; target = '0;
        vectors++; if (ir !== 32'h0) begin miscompares++; $display("FAIL redir_ir got %h exp 0", ir); end
        vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL redir_valid got %b exp 0", ir_valid); end
        vectors++; if (bubble_cnt !== 16'd1) begin miscompares++; $display("FAIL redir_bubble got %0d exp 1", bubble_cnt); end
        vectors++; if (fetch_cnt !== 16'd5) begin miscompares++; $display("FAIL redir_fetch got %0d exp 5", fetch_cnt); end
        tick();
        vectors++; if (ir !== 32'hC000_0008) begin miscompares++; $display("FAIL redir_t_ir got %h exp c0000008", ir); end
        vectors++; if (ir_pc !== 10'd8) begin miscompares++; $display("FAIL redir_t_pc got %0d exp 8", ir_pc); end
        vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("FAIL redir_t_valid got %b exp 1", ir_valid); end
        tick();
        vectors++; if (ir !== 32'hC000_0009) begin miscompares++; $display("FAIL redir_t1_ir got %h exp c0000009", ir); end
        vectors++; if (ir_pc !== 10'd9) begin miscompares++; $display("FAIL redir_t1_pc got %0d exp 9", ir_pc); end
        vectors++; if (fetch_cnt !== 16'd7) begin miscompares++; $display("FAIL redir_t1_fetch got %0d exp 7", fetch_cnt); end
    endtask

    // Redirect and stall together to 0x3FF: redirect wins, then wrap to 0.
    task automatic test_redirect_stall_wrap();
        redirect = 1'b1; stall = 1'b1; target = 10'h3FF;
        #1;
        vectors++; if (mem_addr !== 10'h3FF) begin miscompares++; $display("FAIL rs_addr got %h exp 3ff", mem_addr); end
        tick();
        redirect = 1'b0; stall = 1'b0; target = '0;
        vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL rs_valid got %b exp 0", ir_valid); end
        vectors++; if (bubble_cnt !== 16'd2) begin miscompares++; $display("FAIL rs_bubble got %0d exp 2", bubble_cnt); end
        #1;
        vectors++; if (mem_addr !== 10'd0) begin miscompares++; $display("FAIL rs_wrap_addr got %0d exp 0", mem_addr); end
        tick();
        vectors++; if (ir !== 32'hC000_03FF) begin miscompares++; $display("FAIL rs_ir got %h exp c00003ff", ir); end
        vectors++; if (ir_pc !== 10'h3FF) begin miscompares++; $display("FAIL rs_pc got %h exp 3ff", ir_pc); end
        tick();
        vectors++; if (ir !== 32'h2001_0005) begin miscompares++; $display("FAIL wrap_ir got %h exp 20010005", ir); end
        vectors++; if (ir_pc !== 10'd0) begin miscompares++; $display("FAIL wrap_pc got %0d exp 0", ir_pc); end
        vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_valid got %b exp 1", ir_valid); end
    endtask

    // Reset mid-stream with stall high clears at once; restart as from cold.
    task automatic test_reset_mid();
        stall = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        vectors++; if (ir !== 32'h0) begin miscompares++; $display("FAIL mid_ir got %h exp 0", ir); end
        vectors++; if (ir_pc !== 10'd0) begin miscompares++; $display("FAIL mid_pc got %0d exp 0", ir_pc); end
        vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid got %b exp 0", ir_valid); end
        vectors++; if (fetch_cnt !== 16'd0) begin miscompares++; $display("FAIL mid_fetch got %0d exp 0", fetch_cnt); end
        vectors++; if (bubble_cnt !== 16'd0) begin miscompares++; $display("FAIL mid_bubble got %0d exp 0", bubble_cnt); end
        vectors++; if (mem_addr !== 10'd0) begin miscompares++; $display("FAIL mid_addr got %0d exp 0", mem_addr); end
        stall = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL mid_first_valid got %b exp 0", ir_valid); end
        exp_q.push_back(32'h2001_0005);
        exp_q.push_back(32'h2002_0003);
        exp_q.push_back(32'h0022_1820);
        for (int i = 0; i < 3; i++) begin
            logic [INSTR_W-1:0] e;
            tick();
            e = exp_q.pop_front();
            vectors++; if (ir !== e) begin miscompares++; $display("FAIL mid_ir%0d got %h exp %h", i, ir, e); end
            vectors++; if (ir_pc !== 10'(i)) begin miscompares++; $display("FAIL mid_pc%0d got %0d exp %0d", i, ir_pc, i); end
        end
        vectors++; if (fetch_cnt !== 16'd3) begin miscompares++; $display("FAIL mid_fetch3 got %0d exp 3", fetch_cnt); end
        vectors++; if (bubble_cnt !== 16'd0) begin miscompares++; $display("FAIL mid_bubble0 got %0d exp 0", bubble_cnt); end
    endtask

    // From reset, edge k (k>=2) delivers valid word k-1: check FFFE/FFFF/hold.
    task automatic test_saturation();
        do_reset();
        repeat (65535) tick();
        vectors++; if (fetch_cnt !== 16'hFFFE) begin miscompares++; $display("FAIL sat_fffe got %h exp fffe", fetch_cnt); end
        tick();
        vectors++; if (fetch_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_ffff got %h exp ffff", fetch_cnt); end
        tick();
        vectors++; if (fetch_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold got %h exp ffff", fetch_cnt); end
        vectors++; if (bubble_cnt !== 16'd0) begin miscompares++; $display("FAIL sat_bubble got %0d exp 0", bubble_cnt); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; target = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0000 | 32'(i);
        mem[0] = 32'h2001_0005;
        mem[1] = 32'h2002_0003;
        mem[2] = 32'h0022_1820;
        mem[3] = 32'h0000_0000;

        test_reset();
        test_stall();
        test_redirect();
        test_redirect_stall_wrap();
        test_reset_mid();
        test_saturation();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
